// File: rtl/fp16_add_step2_pipe.sv
// FP16 adder step 2: signed-magnitude add/subtract of aligned fractions behind a
// registered 2-entry skid buffer. Optional statistics counters: ADD_STEP2_STATS_EN.
module fp16_add_step2_pipe #(
    parameter int unsigned FRAC_W = 13,
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_a,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic              sign_b,
    input  logic [FRAC_W-1:0] frac_b,
    input  logic [EXP_W-1:0]  exp_max_in,
    input  logic              round_loss_in,
    input  logic              ovf_in,
    input  logic              unf_in,
    input  logic              dz_in,
    input  logic              inv_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              carry_out,
    output logic [EXP_W-1:0]  exp_max_out,
    output logic              round_loss_out,
    output logic              ovf_out,
    output logic              unf_out,
    output logic              dz_out,
    output logic              inv_out,
    output logic [CNT_W-1:0]  stat_ops,
    output logic [CNT_W-1:0]  stat_cancel
);

    typedef struct packed {
        logic              sign;
        logic [FRAC_W-1:0] frac;
        logic              carry;
        logic [EXP_W-1:0]  exp_max;
        logic              round_loss;
        logic              ovf;
        logic              unf;
        logic              dz;
        logic              inv;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d, skid_q, skid_d, res;
    logic   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic   in_xfer, out_xfer;
    logic [FRAC_W:0] sum_ext;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;
    assign sum_ext  = {1'b0, frac_a} + {1'b0, frac_b};

    // Signed-magnitude combine; exact cancellation falls through to +0.
    always_comb begin
        res            = '0;
        res.exp_max    = exp_max_in;
        res.round_loss = round_loss_in;
        res.ovf        = ovf_in;
        res.unf        = unf_in;
        res.dz         = dz_in;
        res.inv        = inv_in;
        if (sign_a == sign_b) begin
            res.carry = sum_ext[FRAC_W];
            res.frac  = sum_ext[FRAC_W-1:0];
            res.sign  = sign_a;
        end else if (frac_a > frac_b) begin
            res.frac = frac_a - frac_b;
            res.sign = sign_a;
        end else if (frac_b > frac_a) begin
            res.frac = frac_b - frac_a;
            res.sign = sign_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    out_d   = res;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (in_xfer && !out_xfer) begin
                    skid_d  = res;
                    state_d = StFull;
                end else if (!in_xfer && out_xfer) begin
                    state_d = StEmpty;
                end else if (in_xfer && out_xfer) begin
                    out_d = res;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Flags are registered from the next state so in_ready has no comb path from out_ready.
    always_comb begin
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign sign_out       = out_q.sign;
    assign frac_out       = out_q.frac;
    assign carry_out      = out_q.carry;
    assign exp_max_out    = out_q.exp_max;
    assign round_loss_out = out_q.round_loss;
    assign ovf_out        = out_q.ovf;
    assign unf_out        = out_q.unf;
    assign dz_out         = out_q.dz;
    assign inv_out        = out_q.inv;

`ifdef ADD_STEP2_STATS_EN
    logic [CNT_W-1:0] ops_q, cancel_q;
    logic             cancel;

    assign cancel = (sign_a != sign_b) && (frac_a == frac_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q    <= '0;
            cancel_q <= '0;
        end else if (in_xfer) begin
            if (ops_q != '1) ops_q <= ops_q + CNT_W'(1);
            if (cancel && cancel_q != '1) cancel_q <= cancel_q + CNT_W'(1);
        end
    end

    assign stat_ops    = ops_q;
    assign stat_cancel = cancel_q;
`else
    assign stat_ops    = '0;
    assign stat_cancel = '0;
`endif

endmodule

// File: tb/tb_fp16_add_step2_pipe.sv
// Scoreboard bench for fp16_add_step2_pipe: random and directed traffic against an
// integer-arithmetic reference, with backpressure and asynchronous reset.
module tb_fp16_add_step2_pipe;

    localparam int FRAC_W = 13;
    localparam int EXP_W  = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic              sign_a, sign_b;
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic [EXP_W-1:0]  exp_max_in;
    logic              round_loss_in, ovf_in, unf_in, dz_in, inv_in;
    logic              out_valid, out_ready;
    logic              sign_out, carry_out;
    logic [FRAC_W-1:0] frac_out;
    logic [EXP_W-1:0]  exp_max_out;
    logic              round_loss_out, ovf_out, unf_out, dz_out, inv_out;
    logic [CNT_W-1:0]  stat_ops, stat_cancel;

    fp16_add_step2_pipe #(
        .FRAC_W(FRAC_W),
        .EXP_W (EXP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_a        (sign_a),
        .frac_a        (frac_a),
        .sign_b        (sign_b),
        .frac_b        (frac_b),
        .exp_max_in    (exp_max_in),
        .round_loss_in (round_loss_in),
        .ovf_in        (ovf_in),
        .unf_in        (unf_in),
        .dz_in         (dz_in),
        .inv_in        (inv_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sign_out      (sign_out),
        .frac_out      (frac_out),
        .carry_out     (carry_out),
        .exp_max_out   (exp_max_out),
        .round_loss_out(round_loss_out),
        .ovf_out       (ovf_out),
        .unf_out       (unf_out),
        .dz_out        (dz_out),
        .inv_out       (inv_out),
        .stat_ops      (stat_ops),
        .stat_cancel   (stat_cancel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    bit          check_lat = 0;
    bit          rand_bp = 0;
    int          m_ops = 0;
    int          m_cancel = 0;
    bit          held_v = 0;
    logic [24:0] held;
    logic [24:0] actual;

    assign actual = {sign_out, frac_out, carry_out, exp_max_out,
                     round_loss_out, ovf_out, unf_out, dz_out, inv_out};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: signed integer sum of the two operands, split into sign/magnitude.
    function automatic logic [24:0] model(input logic sa, input logic [12:0] fa,
                                          input logic sbb, input logic [12:0] fb,
                                          input logic [4:0] e, input logic [4:0] fl);
        int   ia, ib, d, mag;
        logic s, c;
        ia = fa;
        ib = fb;
        if (sa == sbb) begin
            mag = ia + ib;
            s   = sa;
        end else begin
            d   = (sa ? -ia : ia) + (sbb ? -ib : ib);
            s   = (d < 0);
            mag = (d < 0) ? -d : d;
        end
        c = (mag >= 8192);
        return {s, 13'(mag % 8192), c, e, fl};
    endfunction

    task automatic push_cur();
        exp_t x;
        x.val = model(sign_a, frac_a, sign_b, frac_b, exp_max_in,
                      {round_loss_in, ovf_in, unf_in, dz_in, inv_in});
        x.cyc = cyc;
        sb.push_back(x);
        m_ops++;
        if (sign_a != sign_b && frac_a == frac_b) m_cancel++;
    endtask

    task automatic set_in(input logic sa, input logic [12:0] fa, input logic sbb,
                          input logic [12:0] fb, input logic [4:0] e, input logic [4:0] fl);
        sign_a = sa;
        frac_a = fa;
        sign_b = sbb;
        frac_b = fb;
        exp_max_in = e;
        {round_loss_in, ovf_in, unf_in, dz_in, inv_in} = fl;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic sa, input logic [12:0] fa, input logic sbb,
                        input logic [12:0] fb, input logic [4:0] e, input logic [4:0] fl);
        bit done = 0;
        set_in(sa, fa, sbb, fb, e, fl);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_cur();
                done = 1;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [12:0] fa, fb;
        fa = 13'($urandom);
        fb = ($urandom_range(0, 3) == 0) ? fa : 13'($urandom);
        send(1'($urandom), fa, 1'($urandom), fb, 5'($urandom), 5'($urandom));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic check_stats();
`ifdef ADD_STEP2_STATS_EN
        check("stat_ops", 32'(stat_ops), m_ops);
        check("stat_cancel", 32'(stat_cancel), m_cancel);
`else
        check("stat_ops_tied", 32'(stat_ops), 32'd0);
        check("stat_cancel_tied", 32'(stat_cancel), 32'd0);
`endif
    endtask

    // Monitor: pops on every output transfer and checks stall stability.
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            held_v = 0;
        end else begin
            if (out_valid && held_v) check("stall_stable", 32'(actual), 32'(held));
            if (out_valid && out_ready) begin
                held_v = 0;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(actual), 32'hFFFF_FFFF);
                end else begin
                    x = sb.pop_front();
                    check("result", 32'(actual), 32'(x.val));
                    if (check_lat) check("latency", cyc - x.cyc, 32'd1);
                end
            end else if (out_valid) begin
                held   = actual;
                held_v = 1;
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data", 32'(actual), 32'd0);
        check_stats();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases with out_ready high.
        out_ready = 1'b1;
        check_lat = 1;
        send(0, 13'h1000, 0, 13'h1000, 5'h0F, 5'b00000);
        send(0, 13'h0C00, 1, 13'h1400, 5'h0F, 5'b00000);
        send(1, 13'h1234, 0, 13'h1234, 5'h0A, 5'b10101);
        send(1, 13'h1FFF, 1, 13'h1FFF, 5'h1F, 5'b01010);
        send(1, 13'h0800, 0, 13'h0100, 5'h03, 5'b00001);
        send(0, 13'h0000, 1, 13'h0000, 5'h00, 5'b00000);
        drain();
        check_stats();

        // Backpressure: A and B fill the buffer, C must wait.
        check_lat = 0;
        out_ready = 1'b0;
        set_in(0, 13'h0123, 0, 13'h0456, 5'h01, 5'b00000);
        @(negedge clk);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        if (in_ready) push_cur();
        @(posedge clk);
        #1;
        set_in(1, 13'h0800, 0, 13'h0200, 5'h02, 5'b00010);
        @(negedge clk);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        if (in_ready) push_cur();
        @(posedge clk);
        #1;
        set_in(0, 13'h0333, 1, 13'h0333, 5'h03, 5'b00100);
        @(negedge clk);
        check("bp_c_held", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_c_held2", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_a_leaving", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        if (in_ready) push_cur();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check_stats();

        // Streaming at full rate.
        check_lat = 1;
        out_ready = 1'b1;
        repeat (16) send_rand();
        drain();

        // Random backpressure.
        check_lat = 0;
        rand_bp = 1;
        repeat (40) send_rand();
        rand_bp = 0;
        drain();
        check_stats();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_data", 32'(actual), 32'd0);
        sb.delete();
        m_ops = 0;
        m_cancel = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check_lat = 1;
        send(1, 13'h0ABC, 0, 13'h0ABC, 5'h11, 5'b00000);
        send_rand();
        drain();
        check_stats();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
